// File: rtl/pending_index_encoder_pkg.sv
// Shared defaults and state encoding for the pending-index encoder.
package pending_index_encoder_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_t;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of vec.
module lowest_set_index #(
  parameter int unsigned N  = pending_index_encoder_pkg::N,
  parameter int unsigned IW = pending_index_encoder_pkg::IW
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign found = |vec;

endmodule

// File: rtl/pending_index_encoder.sv
// Accepts a request vector and emits the index of each set bit, lowest first,
// one per output handshake; all-zero vectors are dropped with a pulse.
module pending_index_encoder #(
  parameter int unsigned N  = pending_index_encoder_pkg::N,
  parameter int unsigned IW = pending_index_encoder_pkg::IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_onehot,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          zero_drop
);

  import pending_index_encoder_pkg::*;

  enc_state_t    state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          zero_drop_q, zero_drop_d;
  logic [IW-1:0] low_idx;
  logic          low_found;
  logic          in_hs, out_hs;

  lowest_set_index #(
    .N  (N),
    .IW (IW)
  ) u_lowest (
    .vec   (pend_q),
    .idx   (low_idx),
    .found (low_found)
  );

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    zero_drop_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          if (in_data != '0) begin
            pend_d  = in_data;
            state_d = DRAIN;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (!out_last) begin
            pend_d = pend_q & ~out_onehot;
          end else if (in_hs && (in_data != '0)) begin
            // Back-to-back: next vector loads during the final pop.
            pend_d = in_data;
          end else begin
            pend_d      = '0;
            state_d     = IDLE;
            zero_drop_d = in_hs;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // Output decode from registered state; in_ready also follows out_ready.
  always_comb begin
    out_valid  = 1'b0;
    out_idx    = '0;
    out_onehot = '0;
    out_last   = 1'b0;
    if ((state_q == DRAIN) && low_found) begin
      out_valid  = 1'b1;
      out_idx    = low_idx;
      out_onehot = N'(1) << low_idx;
      out_last   = ((pend_q & (pend_q - N'(1))) == '0);
    end
    in_ready = (state_q == IDLE) || (out_valid && out_last && out_ready);
  end

  assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_pending_index_encoder.sv
// Self-checking bench for pending_index_encoder: directed table, corner
// sequences and a random phase, all cross-checked by a queue scoreboard.
module tb_pending_index_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       zero_drop;

  int pass_cnt = 0;
  int total_cnt = 0;

  pending_index_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .zero_drop  (zero_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: one entry per index the DUT still owes.
  typedef struct {
    logic [2:0] idx;
    logic       last;
  } exp_t;
  exp_t sbq[$];
  logic zd_pend = 1'b0;

  task automatic push_vec(input logic [7:0] v);
    int hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < 8; i++) if (v[i]) hi = i;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        e.idx  = 3'(i);
        e.last = (i == hi);
        sbq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] oh;
    logic       m_ready, hs_in, hs_out;
    if (!rst_n) begin
      sbq.delete();
      zd_pend = 1'b0;
    end else begin
      chk("sb_zero_drop", 32'(zero_drop), 32'(zd_pend));
      chk("sb_out_valid", 32'(out_valid), 32'(sbq.size() != 0));
      if (sbq.size() != 0) begin
        oh = 8'h01 << sbq[0].idx;
        chk("sb_out_idx", 32'(out_idx), 32'(sbq[0].idx));
        chk("sb_out_onehot", 32'(out_onehot), 32'(oh));
        chk("sb_out_last", 32'(out_last), 32'(sbq[0].last));
      end else begin
        chk("sb_idle_outs", 32'({out_idx, out_onehot, out_last}), 32'd0);
      end
      m_ready = (sbq.size() == 0) || ((sbq.size() == 1) && out_ready);
      chk("sb_in_ready", 32'(in_ready), 32'(m_ready));
      hs_out = (sbq.size() != 0) && out_ready;
      hs_in  = in_valid && m_ready;
      zd_pend = 1'b0;
      if (hs_out) void'(sbq.pop_front());
      if (hs_in) begin
        if (in_data == 8'h00) zd_pend = 1'b1;
        else push_vec(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (out_valid && n < 50) begin
      step();
      n++;
    end
    if (out_valid) chk("wait_idle_timeout", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         first;
    int         count;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int cnt, first;
    tbl[0] = '{8'hA4, 2, 3};
    tbl[1] = '{8'h81, 0, 2};
    tbl[2] = '{8'hFF, 0, 8};
    tbl[3] = '{8'h01, 0, 1};
    tbl[4] = '{8'h80, 7, 1};
    tbl[5] = '{8'h5A, 1, 4};
    tbl[6] = '{8'h18, 3, 2};

    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_outs", 32'({out_valid, out_idx, out_onehot, out_last, zero_drop}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic drain of 8'hA4.
    in_data = 8'hA4; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("a4_p0", 32'({out_valid, out_idx, out_onehot, out_last}), 32'({1'b1, 3'd2, 8'h04, 1'b0}));
    step();
    chk("a4_p1", 32'({out_valid, out_idx, out_onehot, out_last}), 32'({1'b1, 3'd5, 8'h20, 1'b0}));
    step();
    chk("a4_p2", 32'({out_valid, out_idx, out_onehot, out_last}), 32'({1'b1, 3'd7, 8'h80, 1'b1}));
    step();
    chk("a4_done", 32'(out_valid), 32'd0);

    // Backpressure on 8'h81.
    out_ready = 1'b0; in_data = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", 32'({out_valid, out_idx, out_last, in_ready}), 32'({1'b1, 3'd0, 1'b0, 1'b0}));
      step();
    end
    out_ready = 1'b1;
    chk("bp_rel0", 32'({out_valid, out_idx}), 32'({1'b1, 3'd0}));
    step();
    chk("bp_rel7", 32'({out_valid, out_idx, out_last}), 32'({1'b1, 3'd7, 1'b1}));
    step();
    chk("bp_done", 32'(out_valid), 32'd0);

    // Back-to-back 8'h01 then 8'h40.
    in_data = 8'h01; in_valid = 1'b1;
    step();
    in_data = 8'h40;
    chk("b2b_first", 32'({out_valid, out_idx, out_last, in_ready}), 32'({1'b1, 3'd0, 1'b1, 1'b1}));
    step();
    in_valid = 1'b0;
    chk("b2b_second", 32'({out_valid, out_idx, out_last}), 32'({1'b1, 3'd6, 1'b1}));
    step();
    chk("b2b_done", 32'(out_valid), 32'd0);

    // Zero vector in IDLE.
    in_data = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("zero_idle", 32'({out_valid, zero_drop, in_ready}), 32'({1'b0, 1'b1, 1'b1}));
    step();
    chk("zero_idle_end", 32'(zero_drop), 32'd0);

    // Zero vector overlapping the last pop of 8'h02.
    in_data = 8'h02; in_valid = 1'b1;
    step();
    in_data = 8'h00;
    chk("zero_ovl_pop", 32'({out_valid, out_idx, out_last}), 32'({1'b1, 3'd1, 1'b1}));
    step();
    in_valid = 1'b0;
    chk("zero_ovl", 32'({out_valid, zero_drop}), 32'({1'b0, 1'b1}));
    step();
    chk("zero_ovl_end", 32'(zero_drop), 32'd0);

    // Reset mid-drain of 8'hFF.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("mid_before", 32'({out_valid, out_idx}), 32'({1'b1, 3'd2}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async", 32'({out_valid, out_idx, out_onehot, out_last}), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    in_data = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mid_after", 32'({out_valid, out_idx, out_last}), 32'({1'b1, 3'd4, 1'b1}));
    step();

    // Table of vectors drained at full rate.
    for (int t = 0; t < 7; t++) begin
      wait_idle();
      in_data = tbl[t].data; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      cnt = 0;
      first = int'(out_idx);
      while (out_valid && cnt < 20) begin
        cnt++;
        step();
      end
      chk($sformatf("tbl%0d_first", t), 32'(first), 32'(tbl[t].first));
      chk($sformatf("tbl%0d_count", t), 32'(cnt), 32'(tbl[t].count));
    end

    // Random traffic; the scoreboard does the checking.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
